// File: rtl/icache_assoc_if.sv
// Fetcher-side and memory-side handshake bundle for icache_assoc.
// The slave modport is the cache's view; master is the fetcher/memory side.
interface icache_assoc_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] fetcher_address;
    logic                 fetcher_read_request;
    logic                 fetcher_read_valid;
    logic [DATA_BITS-1:0] fetcher_read_data;
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport slave (
        input  fetcher_address, fetcher_read_request, mem_read_ready, mem_read_data,
        output fetcher_read_valid, fetcher_read_data, mem_read_valid, mem_read_address
    );

    modport master (
        output fetcher_address, fetcher_read_request, mem_read_ready, mem_read_data,
        input  fetcher_read_valid, fetcher_read_data, mem_read_valid, mem_read_address
    );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative, single-word-line instruction cache with blocking miss handling,
// flush support and saturating hit/miss statistics.
module icache_assoc #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned NUM_SETS  = 8,
    parameter int unsigned NUM_WAYS  = 2,
    parameter int unsigned STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    icache_assoc_if.slave        bus,
    input  logic                 flush,
    output logic [STAT_BITS-1:0] hit_count,
    output logic [STAT_BITS-1:0] miss_count
);
    localparam int unsigned IDX_BITS = $clog2(NUM_SETS);
    localparam int unsigned TAG_BITS = ADDR_BITS - IDX_BITS;
    localparam int unsigned WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
    logic [NUM_SETS-1:0][WAY_BITS-1:0] victim_q;
    logic [TAG_BITS-1:0]               tag_q  [NUM_SETS][NUM_WAYS];
    logic [DATA_BITS-1:0]              data_q [NUM_SETS][NUM_WAYS];

    logic                 rvalid_q, rvalid_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 mvalid_q, mvalid_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 hit_inc, miss_inc, fill_en, clear_all;

    logic [IDX_BITS-1:0]  lookup_idx, fill_idx;
    logic [TAG_BITS-1:0]  lookup_tag, fill_tag;
    logic                 hit_c;
    logic [DATA_BITS-1:0] hit_data_c;
    logic [WAY_BITS-1:0]  victim_c, ptr_next_c;

    assign lookup_idx = bus.fetcher_address[IDX_BITS-1:0];
    assign lookup_tag = bus.fetcher_address[ADDR_BITS-1:IDX_BITS];
    assign fill_idx   = addr_q[IDX_BITS-1:0];
    assign fill_tag   = addr_q[ADDR_BITS-1:IDX_BITS];

    assign bus.fetcher_read_valid = rvalid_q;
    assign bus.fetcher_read_data  = rdata_q;
    assign bus.mem_read_valid     = mvalid_q;
    assign bus.mem_read_address   = addr_q;

    // Tag match across all ways of the requested set
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (valid_q[lookup_idx][w] && (tag_q[lookup_idx][w] == lookup_tag)) begin
                hit_c      = 1'b1;
                hit_data_c = data_q[lookup_idx][w];
            end
        end
    end

    // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer
    always_comb begin
        victim_c = victim_q[fill_idx];
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[fill_idx][w]) begin
                victim_c = WAY_BITS'(w);
            end
        end
        ptr_next_c = victim_q[fill_idx] + WAY_BITS'(1);
        if (NUM_WAYS == 1) begin
            ptr_next_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        mvalid_d     = mvalid_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        fill_en      = 1'b0;
        clear_all    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    clear_all = 1'b1;
                end else if (bus.fetcher_read_request) begin
                    if (hit_c) begin
                        rdata_d  = hit_data_c;
                        rvalid_d = 1'b1;
                        hit_inc  = 1'b1;
                        state_d  = RESP;
                    end else begin
                        addr_d   = bus.fetcher_address;
                        mvalid_d = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            FETCH: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.mem_read_ready) begin
                    fill_en  = 1'b1;
                    rdata_d  = bus.mem_read_data;
                    rvalid_d = 1'b1;
                    mvalid_d = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                // A flush deferred during the transaction takes effect as we re-enter IDLE
                if (flush || flush_pend_q) begin
                    clear_all = 1'b1;
                end
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, valid bits, victim pointers and statistics
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            mvalid_q     <= 1'b0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            victim_q     <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            mvalid_q     <= mvalid_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
            if (clear_all) begin
                valid_q <= '0;
            end else if (fill_en) begin
                valid_q[fill_idx][victim_c] <= 1'b1;
            end
            if (fill_en) begin
                victim_q[fill_idx] <= ptr_next_c;
            end
            if (hit_inc && (hit_count != {STAT_BITS{1'b1}})) begin
                hit_count <= hit_count + STAT_BITS'(1);
            end
            if (miss_inc && (miss_count != {STAT_BITS{1'b1}})) begin
                miss_count <= miss_count + STAT_BITS'(1);
            end
        end
    end

    // Tag and data storage; contents are qualified by valid_q so need no reset
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx][victim_c]  <= fill_tag;
            data_q[fill_idx][victim_c] <= bus.mem_read_data;
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a table of fetch transactions plus hand-written
// flush, reset-abort and counter-saturation sequences.
module tb_icache_assoc;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [31:0] hit_count, miss_count;
    logic [3:0]  sat_hits, sat_misses;

    int n_vec = 0;
    int n_err = 0;

    icache_assoc_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();
    icache_assoc_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus2 ();

    assign bus2.fetcher_address      = bus.fetcher_address;
    assign bus2.fetcher_read_request = bus.fetcher_read_request;
    assign bus2.mem_read_ready       = bus.mem_read_ready;
    assign bus2.mem_read_data        = bus.mem_read_data;

    icache_assoc u_dut (
        .clk(clk), .reset(reset), .bus(bus), .flush(flush),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_assoc #(.STAT_BITS(4)) u_sat (
        .clk(clk), .reset(reset), .bus(bus2), .flush(flush),
        .hit_count(sat_hits), .miss_count(sat_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        bit          hit;
        int          lat;
        logic [15:0] mem_data;
        logic [15:0] exp_data;
        int          exp_hits;
        int          exp_miss;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch; entered and left one step after a rising edge, cache in IDLE
    task automatic do_fetch(input logic [7:0] a, input bit exp_hit, input int lat,
                            input logic [15:0] md, input logic [15:0] ed,
                            input int eh, input int em);
        bus.fetcher_address      = a;
        bus.fetcher_read_request = 1'b1;
        tick();
        if (exp_hit) begin
            check("hit_valid", 32'(bus.fetcher_read_valid), 32'd1);
            check("hit_no_mem", 32'(bus.mem_read_valid), 32'd0);
        end else begin
            check("miss_mem_valid", 32'(bus.mem_read_valid), 32'd1);
            check("miss_mem_addr", 32'(bus.mem_read_address), 32'(a));
            check("miss_no_resp", 32'(bus.fetcher_read_valid), 32'd0);
            for (int i = 0; i < lat; i++) begin
                tick();
                check("mem_hold_valid", 32'(bus.mem_read_valid), 32'd1);
                check("mem_hold_addr", 32'(bus.mem_read_address), 32'(a));
            end
            bus.mem_read_ready = 1'b1;
            bus.mem_read_data  = md;
            tick();
            bus.mem_read_ready = 1'b0;
            check("fill_valid", 32'(bus.fetcher_read_valid), 32'd1);
            check("fill_mem_drop", 32'(bus.mem_read_valid), 32'd0);
        end
        check("resp_data", 32'(bus.fetcher_read_data), 32'(ed));
        bus.fetcher_read_request = 1'b0;
        tick();
        check("resp_one_cycle", 32'(bus.fetcher_read_valid), 32'd0);
        check("hit_count", hit_count, 32'(eh));
        check("miss_count", miss_count, 32'(em));
    endtask

    initial begin
        vecs[0]  = '{8'h05, 1'b0, 3, 16'hABCD, 16'hABCD, 0, 1};
        vecs[1]  = '{8'h05, 1'b1, 0, 16'h0000, 16'hABCD, 1, 1};
        vecs[2]  = '{8'h0D, 1'b0, 1, 16'h1111, 16'h1111, 1, 2};
        vecs[3]  = '{8'h15, 1'b0, 0, 16'h2222, 16'h2222, 1, 3};
        vecs[4]  = '{8'h0D, 1'b1, 0, 16'h0000, 16'h1111, 2, 3};
        vecs[5]  = '{8'h15, 1'b1, 0, 16'h0000, 16'h2222, 3, 3};
        vecs[6]  = '{8'h05, 1'b0, 2, 16'h3333, 16'h3333, 3, 4};
        vecs[7]  = '{8'h0D, 1'b0, 0, 16'h4444, 16'h4444, 3, 5};
        vecs[8]  = '{8'h05, 1'b1, 0, 16'h0000, 16'h3333, 4, 5};
        vecs[9]  = '{8'h03, 1'b0, 1, 16'h5555, 16'h5555, 4, 6};
        vecs[10] = '{8'h03, 1'b1, 0, 16'h0000, 16'h5555, 5, 6};
        vecs[11] = '{8'hFF, 1'b0, 0, 16'hBEEF, 16'hBEEF, 5, 7};
        vecs[12] = '{8'hFF, 1'b1, 0, 16'h0000, 16'hBEEF, 6, 7};

        bus.fetcher_address      = '0;
        bus.fetcher_read_request = 1'b0;
        bus.mem_read_ready       = 1'b0;
        bus.mem_read_data        = '0;

        repeat (2) tick();
        check("rst_rvalid", 32'(bus.fetcher_read_valid), 32'd0);
        check("rst_mvalid", 32'(bus.mem_read_valid), 32'd0);
        check("rst_rdata", 32'(bus.fetcher_read_data), 32'd0);
        check("rst_maddr", 32'(bus.mem_read_address), 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_sat_hits", 32'(sat_hits), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            do_fetch(vecs[i].addr, vecs[i].hit, vecs[i].lat, vecs[i].mem_data,
                     vecs[i].exp_data, vecs[i].exp_hits, vecs[i].exp_miss);
        end

        // Flush in IDLE wins over a simultaneous request and leaves counters alone
        bus.fetcher_address      = 8'h05;
        bus.fetcher_read_request = 1'b1;
        flush                    = 1'b1;
        tick();
        flush                    = 1'b0;
        bus.fetcher_read_request = 1'b0;
        check("flush_idle_rvalid", 32'(bus.fetcher_read_valid), 32'd0);
        check("flush_idle_mvalid", 32'(bus.mem_read_valid), 32'd0);
        check("flush_idle_hits", hit_count, 32'd6);
        check("flush_idle_misses", miss_count, 32'd7);
        tick();
        do_fetch(8'h05, 1'b0, 0, 16'h6666, 16'h6666, 6, 8);
        do_fetch(8'h03, 1'b0, 1, 16'h7777, 16'h7777, 6, 9);

        // Flush pulse while a fill is outstanding: data still returned, line dropped after
        bus.fetcher_address      = 8'h22;
        bus.fetcher_read_request = 1'b1;
        tick();
        check("fflush_mvalid", 32'(bus.mem_read_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fflush_hold", 32'(bus.mem_read_valid), 32'd1);
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'h2A2A;
        tick();
        bus.mem_read_ready       = 1'b0;
        bus.fetcher_read_request = 1'b0;
        check("fflush_rvalid", 32'(bus.fetcher_read_valid), 32'd1);
        check("fflush_rdata", 32'(bus.fetcher_read_data), 32'h2A2A);
        tick();
        check("fflush_one_cycle", 32'(bus.fetcher_read_valid), 32'd0);
        do_fetch(8'h22, 1'b0, 0, 16'h3B3B, 16'h3B3B, 6, 11);

        // Reset while a fill is outstanding; a late memory response must be ignored
        bus.fetcher_address      = 8'h05;
        bus.fetcher_read_request = 1'b1;
        tick();
        check("rfetch_mvalid", 32'(bus.mem_read_valid), 32'd1);
        reset                    = 1'b0;
        bus.fetcher_read_request = 1'b0;
        tick();
        check("rfetch_mvalid_clr", 32'(bus.mem_read_valid), 32'd0);
        check("rfetch_maddr_clr", 32'(bus.mem_read_address), 32'd0);
        check("rfetch_hits_clr", hit_count, 32'd0);
        check("rfetch_misses_clr", miss_count, 32'd0);
        reset              = 1'b1;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = 16'h9999;
        tick();
        bus.mem_read_ready = 1'b0;
        check("late_ready_rvalid", 32'(bus.fetcher_read_valid), 32'd0);
        check("late_ready_mvalid", 32'(bus.mem_read_valid), 32'd0);
        do_fetch(8'h05, 1'b0, 1, 16'hAAAA, 16'hAAAA, 0, 1);

        // Twenty hits: the 4-bit instance saturates at 15, the 32-bit one keeps counting
        for (int i = 1; i <= 20; i++) begin
            do_fetch(8'h05, 1'b1, 0, 16'h0000, 16'hAAAA, i, 1);
        end
        check("sat_hits", 32'(sat_hits), 32'd15);
        check("sat_misses", 32'(sat_misses), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, program-memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, instruction width.
REQ-003 SHALL have parameter NUM_SETS, default 8, set count; power of 2, >=2.
REQ-004 SHALL have parameter NUM_WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-005 SHALL have parameter STAT_BITS, default 32, width of each statistics counter.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-008 SHALL have port fetcher_address  input  ADDR_BITS  requested instruction address.
REQ-009 SHALL have port fetcher_read_request  input  1  fetch request; held until fetcher_read_valid.
REQ-010 SHALL have port fetcher_read_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have port fetcher_read_data  output  DATA_BITS  instruction returned.
REQ-012 SHALL have port mem_read_valid  output  1  memory read request.
REQ-013 SHALL have port mem_read_address  output  ADDR_BITS  memory read address.
REQ-014 SHALL have port mem_read_ready  input  1  memory data valid this cycle.
REQ-015 SHALL have port mem_read_data  input  DATA_BITS  memory read data.
REQ-016 SHALL have port flush  input  1  invalidate all lines.
REQ-017 SHALL have port hit_count  output  STAT_BITS  lookup hits since reset.
REQ-018 SHALL have port miss_count  output  STAT_BITS  lookup misses since reset.

Function
REQ-019 SHALL use index = fetcher_address[log2(NUM_SETS)-1:0]; tag = remaining upper bits.
REQ-020 SHALL store per set and way: valid bit, tag, DATA_BITS data word; plus one per-set victim pointer of log2(NUM_WAYS) bits (0 bits when NUM_WAYS=1).
REQ-021 SHALL implement states IDLE, FETCH, RESP.
REQ-022 SHALL, in IDLE with request and hit in any way: fetcher_read_data <= hit way data, fetcher_read_valid <= 1, hit_count+1, go RESP (response 1 cycle after request sampled).
REQ-023 SHALL, in IDLE with request and miss: mem_read_address <= fetcher_address, mem_read_valid <= 1, miss_count+1, latch address, go FETCH.
REQ-024 SHALL hold mem_read_valid and mem_read_address stable in FETCH until mem_read_ready=1.
REQ-025 SHALL, in FETCH with mem_read_ready=1: write line (tag, data, valid=1) into victim way, fetcher_read_data <= mem_read_data, fetcher_read_valid <= 1, mem_read_valid <= 0, go RESP.
REQ-026 SHALL select victim as lowest-numbered invalid way in the set; if all valid, the set's victim pointer; pointer advances by 1 modulo NUM_WAYS after every fill into that set.
REQ-027 SHALL, in RESP: fetcher_read_valid <= 0, ignore fetcher_read_request, go IDLE.
REQ-028 SHALL hold fetcher_read_valid high exactly one cycle per response.
REQ-029 SHALL, with flush=1 in IDLE: clear all valid bits that cycle, ignore request, stay IDLE, leave counters unchanged.
REQ-030 SHALL latch flush seen in FETCH or RESP as pending; fill still completes and data is still returned; all valid bits cleared on entry to IDLE.
REQ-031 SHALL saturate hit_count and miss_count at 2^STAT_BITS-1.
REQ-032 SHALL never issue a second memory request while one is outstanding.

Reset
REQ-033 SHALL, on reset=0 at a clock edge, from any state: state IDLE, all valid bits 0, victim pointers 0, fetcher_read_valid 0, mem_read_valid 0, fetcher_read_data 0, mem_read_address 0, hit_count 0, miss_count 0, pending flush 0.
REQ-034 SHALL abandon any outstanding fill on reset; a mem_read_ready arriving afterwards is ignored.

Verification (defaults unless noted)
REQ-035 Cold miss 0x05, mem_read_ready after 3 cycles with 0xABCD -> mem_read_address 0x05, fetcher_read_data 0xABCD with one-cycle valid, miss_count 1; repeat 0x05 -> valid 1 cycle after request, no mem_read_valid, hit_count 1.
REQ-036 Conflict: fill 0x05, 0x0D (set 5, ways 0/1), then 0x15 -> evicts 0x05; 0x0D hits, 0x05 misses.
REQ-037 Fill 0x05, flush in IDLE, request 0x05 -> miss, mem_read_valid asserted, miss_count increments.
REQ-038 flush pulse during FETCH of 0x22 -> data still returned; next request 0x22 misses.
REQ-039 reset=0 mid-FETCH -> next cycle mem_read_valid 0, counters 0; later request 0x05 misses.
REQ-040 STAT_BITS=4, 1 miss then 20 hits of 0x05 -> hit_count 15, miss_count 1.
